// File: rtl/demux_buffer_pkg.sv
// rtl/demux_buffer_pkg.sv - shared select encoding, default widths and occupancy type for demux_buffer
package demux_buffer_pkg;

    localparam logic DEST_0       = 1'b0;
    localparam logic DEST_1       = 1'b1;
    localparam int   SIZE_DEFAULT = 32;
    localparam int   CNT_DEFAULT  = 16;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/demux_buffer_fifo2.sv
// rtl/demux_buffer_fifo2.sv - two-entry FIFO with registered head, one per demux output
module fifo2
    import demux_buffer_pkg::*;
#(
    parameter int W = SIZE_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   occ,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;
    occ_t         occ_q, occ_d;
    logic         do_push;
    logic         do_pop;
    occ_t         wr_idx;

    assign full      = (occ_q == OCC_FULL);
    assign empty     = (occ_q == OCC_EMPTY);
    assign occ       = occ_q;
    assign head_data = ent0_q;

    // Entry 0 is always the head: a pop shifts entry 1 down, a push lands in the first free slot after the pop.
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        do_pop  = pop && !empty;
        do_push = push && !full;
        wr_idx  = occ_q - {1'b0, do_pop};
        occ_d   = occ_q + {1'b0, do_push} - {1'b0, do_pop};
        if (do_pop) begin
            ent0_d = ent1_q;
        end
        if (do_push) begin
            if (wr_idx == 2'd0) begin
                ent0_d = push_data;
            end else begin
                ent1_d = push_data;
            end
        end
    end

    // Storage and occupancy registers; reset discards every buffered word.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= OCC_EMPTY;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

endmodule

// File: rtl/demux_buffer.sv
// rtl/demux_buffer.sv - 1-to-2 stream router with a 2-entry buffer and transfer counter per output
module demux_buffer
    import demux_buffer_pkg::*;
#(
    parameter int size  = SIZE_DEFAULT,
    parameter int CNT_W = CNT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sel,
    input  logic [size-1:0]   in_data,
    output logic              out_0_valid,
    input  logic              out_0_ready,
    output logic [size-1:0]   out_0_data,
    output logic              out_1_valid,
    input  logic              out_1_ready,
    output logic [size-1:0]   out_1_data,
    output logic [CNT_W-1:0]  count_0,
    output logic [CNT_W-1:0]  count_1
);

    logic [size-1:0]  head_0, head_1;
    logic [1:0]       occ_0, occ_1;
    logic             full_0, full_1;
    logic             empty_0, empty_1;
    logic             push_0, push_1;
    logic             pop_0, pop_1;
    logic [CNT_W-1:0] count_0_q, count_0_d;
    logic [CNT_W-1:0] count_1_q, count_1_d;

    // Readiness depends only on the selected buffer's registered fill level, never on valid or downstream ready.
    assign in_ready = !rst && ((sel == DEST_1) ? !full_1 : !full_0);

    assign push_0 = in_valid && in_ready && (sel == DEST_0);
    assign push_1 = in_valid && in_ready && (sel == DEST_1);

    assign out_0_valid = !rst && !empty_0;
    assign out_1_valid = !rst && !empty_1;
    assign out_0_data  = rst ? '0 : head_0;
    assign out_1_data  = rst ? '0 : head_1;

    assign pop_0 = out_0_valid && out_0_ready;
    assign pop_1 = out_1_valid && out_1_ready;

    assign count_0 = count_0_q;
    assign count_1 = count_1_q;

    fifo2 #(.W(size)) u_fifo_0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push_0),
        .push_data (in_data),
        .pop       (pop_0),
        .head_data (head_0),
        .occ       (occ_0),
        .full      (full_0),
        .empty     (empty_0)
    );

    fifo2 #(.W(size)) u_fifo_1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push_1),
        .push_data (in_data),
        .pop       (pop_1),
        .head_data (head_1),
        .occ       (occ_1),
        .full      (full_1),
        .empty     (empty_1)
    );

    // Accepted-word counters advance on each push and wrap modulo 2^CNT_W.
    always_comb begin
        count_0_d = count_0_q + {{(CNT_W-1){1'b0}}, push_0};
        count_1_d = count_1_q + {{(CNT_W-1){1'b0}}, push_1};
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_0_q <= '0;
            count_1_q <= '0;
        end else begin
            count_0_q <= count_0_d;
            count_1_q <= count_1_d;
        end
    end

endmodule
